delay_table: RTL and testbench
==============================

DELAY_TABLE -- requirements
Module: delay_table

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of output channels (1..16).
REQ-002 SHALL have parameter ADDR_W, default 11, meaning wave-ID width; per-channel table depth is 2**ADDR_W.
REQ-003 SHALL have parameter DLY_W, default 24, meaning delay width in clock cycles.
REQ-004 SHALL have port I_CLK  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port I_RST_N  input  1  synchronous active-low reset.
REQ-006 SHALL have ports I_WR_VALID input 1, O_WR_READY output 1: write handshake from the UART command parser.
REQ-007 SHALL have ports I_WR_CH input clog2(N_CH), I_WR_ADDR input ADDR_W, I_WR_DELAY input DLY_W: write channel, wave ID, delay value.
REQ-008 SHALL have port I_TRIG  input  N_CH  per-channel trigger pulse.
REQ-009 SHALL have port I_WAVE_ID  input  N_CH*ADDR_W  per-channel wave ID, sampled with I_TRIG.
REQ-010 SHALL have port I_ABORT  input  N_CH  per-channel cancel of a pending delay.
REQ-011 SHALL have ports O_FIRE output N_CH and O_FIRE_ID output N_CH*ADDR_W: fire pulse and the wave ID it belongs to.
REQ-012 SHALL have ports O_CH_DELAY output N_CH*DLY_W (last looked-up delay), O_BUSY output N_CH (channel not IDLE), O_TRIG_ERR output N_CH (one-cycle rejected-trigger pulse), O_INIT_DONE output 1.

Function
REQ-013 After reset the block SHALL zero every table entry of every channel, one address per cycle, 2**ADDR_W cycles, then assert O_INIT_DONE (held high until next reset).
REQ-014 O_WR_READY SHALL equal O_INIT_DONE; a write occurs in any cycle with I_WR_VALID and O_WR_READY both high, storing I_WR_DELAY at I_WR_ADDR of channel I_WR_CH.
REQ-015 I_WR_CH >= N_CH SHALL cause the write to be accepted and discarded.
REQ-016 Each channel SHALL run an independent FSM with states IDLE, LOOKUP, COUNT, FIRE.
REQ-017 IDLE->LOOKUP when I_TRIG[ch] is high and O_INIT_DONE is high; the wave ID is captured.
REQ-018 LOOKUP->COUNT after one cycle; the counter loads the table value D and O_CH_DELAY[ch] updates to D.
REQ-019 COUNT: if counter==0 go to FIRE, else decrement and remain.
REQ-020 FIRE: O_FIRE[ch] high for exactly one cycle with O_FIRE_ID[ch] = captured wave ID, then IDLE.
REQ-021 Fire latency SHALL be D+3 cycles after the trigger-sampling cycle (D=0 gives 3); D = 2**DLY_W-1 SHALL not wrap.
REQ-022 I_TRIG[ch] in any state other than IDLE, or before O_INIT_DONE, SHALL be ignored and pulse O_TRIG_ERR[ch] in the following cycle.
REQ-023 I_ABORT[ch] in LOOKUP or COUNT SHALL return that channel to IDLE next cycle without O_FIRE; I_ABORT has priority over I_TRIG in the same cycle; ignored in IDLE/FIRE.
REQ-024 A write and a lookup of the same channel and address in the same cycle SHALL return the old value (read-first).
REQ-025 O_FIRE_ID SHALL be zero when O_FIRE is low.

Reset
REQ-026 With I_RST_N low at a clock edge: all FSMs IDLE, counters 0, O_FIRE, O_FIRE_ID, O_CH_DELAY, O_BUSY, O_TRIG_ERR, O_INIT_DONE, O_WR_READY all 0, init-clear address 0.
REQ-027 Reset asserted mid-countdown or mid-init SHALL abandon the operation without any O_FIRE and restart the full init-clear.

Structure
REQ-028 A shared package delay_pkg SHALL hold the channel state encoding (IDLE/LOOKUP/COUNT/FIRE) and the default parameter constants.
REQ-029 Per-channel FSM plus counter SHALL be a sub-module delay_ch_fsm instantiated N_CH times; table storage SHALL be one inferred simple-dual-port RAM per channel.

Verification
REQ-030 Reset release -> O_WR_READY low for 2048 cycles (defaults), then high; trigger on ch0, ID 5 -> O_FIRE[0] at +3 cycles (D=0).
REQ-031 Write ch2 ID 100 D=10, trigger ch2 ID 100 at cycle t -> O_FIRE[2] at t+13, O_FIRE_ID[2]=100, O_CH_DELAY[2]=10.
REQ-032 Trigger ch1 D=50, re-trigger at +5 -> O_TRIG_ERR[1] pulse at +6, single O_FIRE[1] at +53.
REQ-033 Trigger ch3 D=50, I_ABORT[3] at +20 -> O_BUSY[3] low at +21, no O_FIRE[3]; new trigger then accepted.
REQ-034 All four channels triggered same cycle with D=7,0,7,2**24-1 (two shortest checked) -> fires at +10,+3,+10; ch3 aborted by reset, no fire, init restarts.

Source files
------------

// File: rtl/delay_pkg.sv
// delay_pkg: channel state encoding and default sizing
// shared by delay_table and delay_ch_fsm.
package delay_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int ADDR_W_DEF = 11;
  localparam int DLY_W_DEF  = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_COUNT,
    ST_FIRE
  } ch_state_e;

  // channel-select width; never zero so N_CH=1 still has a port bit
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_table_if.sv
// delay_table_if: delay-table write handshake
// master drives valid/ch/addr/delay, slave returns ready.
interface delay_table_if #(
  parameter int CH_W   = 2,
  parameter int ADDR_W = 11,
  parameter int DLY_W  = 24
) ();

  logic              I_WR_VALID;
  logic              O_WR_READY;
  logic [CH_W-1:0]   I_WR_CH;
  logic [ADDR_W-1:0] I_WR_ADDR;
  logic [DLY_W-1:0]  I_WR_DELAY;

  modport master (
    output I_WR_VALID,
    output I_WR_CH,
    output I_WR_ADDR,
    output I_WR_DELAY,
    input  O_WR_READY
  );

  modport slave (
    input  I_WR_VALID,
    input  I_WR_CH,
    input  I_WR_ADDR,
    input  I_WR_DELAY,
    output O_WR_READY
  );

endinterface

// File: rtl/delay_ch_fsm.sv
// delay_ch_fsm: one channel IDLE/LOOKUP/COUNT/FIRE sequencer
// ports: trig/abort/wave_id in, table value in, fire/status out.
module delay_ch_fsm
  import delay_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DLY_W  = DLY_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              trig,
  input  logic              abort,
  input  logic [ADDR_W-1:0] wave_id,
  input  logic [DLY_W-1:0]  tbl_dly,
  output logic              fire,
  output logic [ADDR_W-1:0] fire_id,
  output logic [DLY_W-1:0]  ch_delay,
  output logic              busy,
  output logic              trig_err
);

  ch_state_e         state_q, state_d;
  logic [DLY_W-1:0]  cnt_q, cnt_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [ADDR_W-1:0] id_q, id_d;
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    id_d    = id_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          if (init_done) begin
            state_d = ST_LOOKUP;
            id_d    = wave_id;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOOKUP: begin
        err_d = trig;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          // table read was issued on the trigger edge
          state_d = ST_COUNT;
          cnt_d   = tbl_dly;
          dly_d   = tbl_dly;
        end
      end
      ST_COUNT: begin
        err_d = trig;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_FIRE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIRE: begin
        err_d   = trig;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign fire     = (state_q == ST_FIRE);
  assign fire_id  = fire ? id_q : '0;
  assign ch_delay = dly_q;
  assign busy     = (state_q != ST_IDLE);
  assign trig_err = err_q;

endmodule

// File: rtl/delay_table.sv
// delay_table: per-channel wave-ID -> delay RAM plus fire sequencers
// ports: clk/rst, write bus (wr), trig/id/abort in, fire/status out.
module delay_table
  import delay_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DLY_W  = DLY_W_DEF
) (
  input  logic                   I_CLK,
  input  logic                   I_RST_N,
  delay_table_if.slave           wr,
  input  logic [N_CH-1:0]        I_TRIG,
  input  logic [N_CH*ADDR_W-1:0] I_WAVE_ID,
  input  logic [N_CH-1:0]        I_ABORT,
  output logic [N_CH-1:0]        O_FIRE,
  output logic [N_CH*ADDR_W-1:0] O_FIRE_ID,
  output logic [N_CH*DLY_W-1:0]  O_CH_DELAY,
  output logic [N_CH-1:0]        O_BUSY,
  output logic [N_CH-1:0]        O_TRIG_ERR,
  output logic                   O_INIT_DONE
);

  localparam int CH_W = ch_w(N_CH);

  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              done_q, done_d;
  logic              wr_fire;

  always_comb begin
    clr_addr_d = clr_addr_q;
    done_d     = done_q;
    if (!done_q) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == '1) done_d = 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      clr_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      clr_addr_q <= clr_addr_d;
      done_q     <= done_d;
    end
  end

  assign O_INIT_DONE   = done_q;
  assign wr.O_WR_READY = done_q;
  assign wr_fire       = wr.I_WR_VALID & done_q;

  for (genvar g = 0; g < N_CH; g++) begin : gen_ch
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;
    logic [DLY_W-1:0]  wd;
    logic [DLY_W-1:0]  rd_q;
    logic [DLY_W-1:0]  mem [2**ADDR_W];

    // init sweep owns the write port until done;
    // out-of-range channel numbers match no bank
    always_comb begin
      we = 1'b1;
      wa = clr_addr_q;
      wd = '0;
      if (done_q) begin
        we = wr_fire && (wr.I_WR_CH == CH_W'(g));
        wa = wr.I_WR_ADDR;
        wd = wr.I_WR_DELAY;
      end
    end

    assign ra = I_WAVE_ID[g*ADDR_W +: ADDR_W];

    // read-first SDP RAM, read on the trigger edge
    always_ff @(posedge I_CLK) begin
      if (we) mem[wa] <= wd;
      rd_q <= mem[ra];
    end

    delay_ch_fsm #(
      .ADDR_W (ADDR_W),
      .DLY_W  (DLY_W)
    ) u_fsm (
      .clk       (I_CLK),
      .rst_n     (I_RST_N),
      .init_done (done_q),
      .trig      (I_TRIG[g]),
      .abort     (I_ABORT[g]),
      .wave_id   (ra),
      .tbl_dly   (rd_q),
      .fire      (O_FIRE[g]),
      .fire_id   (O_FIRE_ID[g*ADDR_W +: ADDR_W]),
      .ch_delay  (O_CH_DELAY[g*DLY_W +: DLY_W]),
      .busy      (O_BUSY[g]),
      .trig_err  (O_TRIG_ERR[g])
    );
  end

endmodule

// File: tb/tb_delay_table.sv
// tb_delay_table: directed bench for delay_table
// default sizing: 4 channels, 11-bit IDs, 24-bit delays.
module tb_delay_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  trig;
  logic [3:0]  abort;
  logic [43:0] wave_id;
  logic [3:0]  fire;
  logic [43:0] fire_id_w;
  logic [95:0] ch_dly;
  logic [3:0]  busy;
  logic [3:0]  terr;
  logic        done;

  int checks = 0;
  int errors = 0;
  int t;
  int n;
  int fire_t [4];
  int fire_n [4];
  int err_t  [4];
  logic [10:0] fid [4];

  delay_table_if #(
    .CH_W(2), .ADDR_W(11), .DLY_W(24)
  ) wr_if ();

  delay_table dut (
    .I_CLK       (clk),
    .I_RST_N     (rst_n),
    .wr          (wr_if),
    .I_TRIG      (trig),
    .I_WAVE_ID   (wave_id),
    .I_ABORT     (abort),
    .O_FIRE      (fire),
    .O_FIRE_ID   (fire_id_w),
    .O_CH_DELAY  (ch_dly),
    .O_BUSY      (busy),
    .O_TRIG_ERR  (terr),
    .O_INIT_DONE (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    t = 0;
    for (int c = 0; c < 4; c++) begin
      fire_t[c] = -1;
      fire_n[c] = 0;
      err_t[c]  = -1;
      fid[c]    = '0;
    end
  endtask

  task automatic step_rec();
    step();
    t++;
    for (int c = 0; c < 4; c++) begin
      if (fire[c]) begin
        fire_n[c]++;
        if (fire_t[c] < 0) begin
          fire_t[c] = t;
          fid[c]    = fire_id_w[c*11 +: 11];
        end
      end
      if (terr[c] && err_t[c] < 0) err_t[c] = t;
    end
  endtask

  task automatic wr(input int ch, input int a,
                    input logic [23:0] d);
    wr_if.I_WR_VALID = 1'b1;
    wr_if.I_WR_CH    = 2'(ch);
    wr_if.I_WR_ADDR  = 11'(a);
    wr_if.I_WR_DELAY = d;
    step();
    wr_if.I_WR_VALID = 1'b0;
  endtask

  task automatic set_id(input int ch, input int id);
    wave_id[ch*11 +: 11] = 11'(id);
  endtask

  initial begin
    rst_n = 1'b0;
    trig = '0;
    abort = '0;
    wave_id = '0;
    wr_if.I_WR_VALID = 1'b0;
    wr_if.I_WR_CH    = '0;
    wr_if.I_WR_ADDR  = '0;
    wr_if.I_WR_DELAY = '0;
    repeat (3) step();

    chk("rst_done", done, 0);
    chk("rst_ready", wr_if.O_WR_READY, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fire", fire, 0);
    chk("rst_dly", ch_dly[63:0], 0);
    chk("rst_err", terr, 0);

    // trigger before init completes is rejected
    rst_n = 1'b1;
    trig = 4'b0010;
    step();
    trig = '0;
    chk("early_trig_err", terr, 4'b0010);
    chk("early_trig_busy", busy, 0);
    step();
    chk("early_err_1cyc", terr, 0);
    n = 2;
    while (!wr_if.O_WR_READY && n < 5000) begin
      step();
      n++;
    end
    chk("init_cycles", n, 2048);
    chk("init_done", done, 1);

    // ch0 ID 5, cleared table -> D=0
    arm();
    set_id(0, 5);
    trig = 4'b0001;
    step_rec();
    trig = '0;
    repeat (6) step_rec();
    chk("d0_lat", fire_t[0], 3);
    chk("d0_id", fid[0], 5);
    chk("d0_count", fire_n[0], 1);
    chk("id_zero_idle", fire_id_w, 0);

    // ch2 ID 100 D=10
    wr(2, 100, 24'd10);
    arm();
    set_id(2, 100);
    trig = 4'b0100;
    step_rec();
    trig = '0;
    repeat (15) step_rec();
    chk("d10_lat", fire_t[2], 13);
    chk("d10_id", fid[2], 100);
    chk("d10_dly", ch_dly[71:48], 10);
    chk("d10_count", fire_n[2], 1);

    // ch1 D=50, re-trigger at +5
    wr(1, 9, 24'd50);
    arm();
    set_id(1, 9);
    trig = 4'b0010;
    step_rec();
    trig = '0;
    while (t < 5) step_rec();
    trig = 4'b0010;
    step_rec();
    trig = '0;
    chk("retrig_err_t", err_t[1], 6);
    while (t < 60) step_rec();
    chk("retrig_lat", fire_t[1], 53);
    chk("retrig_count", fire_n[1], 1);

    // ch3 D=50, abort at +20
    wr(3, 3, 24'd50);
    arm();
    set_id(3, 3);
    trig = 4'b1000;
    step_rec();
    trig = '0;
    while (t < 20) step_rec();
    chk("abort_busy_pre", busy[3], 1);
    abort = 4'b1000;
    step_rec();
    abort = '0;
    chk("abort_busy_t", busy[3], 0);
    while (t < 60) step_rec();
    chk("abort_nofire", fire_n[3], 0);
    arm();
    trig = 4'b1000;
    step_rec();
    trig = '0;
    chk("after_abort_busy", busy[3], 1);
    while (t < 56) step_rec();
    chk("after_abort_lat", fire_t[3], 53);
    chk("after_abort_err", err_t[3], -1);

    // same-cycle write and lookup returns old value
    arm();
    set_id(0, 7);
    wr_if.I_WR_VALID = 1'b1;
    wr_if.I_WR_CH    = 2'd0;
    wr_if.I_WR_ADDR  = 11'd7;
    wr_if.I_WR_DELAY = 24'd20;
    trig = 4'b0001;
    step_rec();
    trig = '0;
    wr_if.I_WR_VALID = 1'b0;
    repeat (8) step_rec();
    chk("rdfirst_lat", fire_t[0], 3);
    chk("rdfirst_dly", ch_dly[23:0], 0);
    arm();
    trig = 4'b0001;
    step_rec();
    trig = '0;
    repeat (28) step_rec();
    chk("newval_lat", fire_t[0], 23);
    chk("newval_dly", ch_dly[23:0], 20);

    // all four channels at once, ch3 at max delay
    wr(0, 1, 24'd7);
    wr(1, 1, 24'd0);
    wr(2, 1, 24'd7);
    wr(3, 1, 24'hFFFFFF);
    arm();
    for (int c = 0; c < 4; c++) set_id(c, 1);
    trig = 4'b1111;
    step_rec();
    trig = '0;
    while (t < 12) step_rec();
    chk("all_lat0", fire_t[0], 10);
    chk("all_lat1", fire_t[1], 3);
    chk("all_lat2", fire_t[2], 10);
    chk("all_busy3", busy[3], 1);
    chk("max_dly", ch_dly[95:72], 24'hFFFFFF);

    // reset mid-countdown: no fire, init restarts
    rst_n = 1'b0;
    step_rec();
    chk("rst2_busy", busy, 0);
    chk("rst2_done", done, 0);
    chk("rst2_dly", ch_dly[95:32], 0);
    rst_n = 1'b1;
    n = 0;
    while (!done && n < 5000) begin
      step_rec();
      n++;
    end
    chk("reinit_cycles", n, 2048);
    chk("rst2_nofire3", fire_n[3], 0);

    // table cleared again: ch2 ID 1 back to D=0
    arm();
    trig = 4'b0100;
    step_rec();
    trig = '0;
    repeat (6) step_rec();
    chk("cleared_lat", fire_t[2], 3);
    chk("cleared_dly", ch_dly[71:48], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
